// File: rtl/note_pkg.sv
// Shared types and constants for the note lane display path.
// FSM state encoding plus coordinate widths and default screen geometry.
package note_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int Y_W      = 32;
  localparam int X_W      = 10;
  localparam int WIDTH_W  = 7;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;

endpackage

// File: rtl/note_slot.sv
// One note slot: valid bit and y position; load wins over advance, clear wins over both.
// Advance either moves the note down by SPEED or retires it once it passes BOTTOM_Y.
module note_slot
  import note_pkg::*;
#(
  parameter logic [Y_W-1:0] SPEED    = 32'd2,
  parameter logic [Y_W-1:0] BOTTOM_Y = Y_W'(SCREEN_H),
  parameter logic [Y_W-1:0] HIT_Y_LO = 32'd400,
  parameter logic [Y_W-1:0] HIT_Y_HI = 32'd440
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_load,
  input  logic           i_adv,
  input  logic           i_clear,
  output logic           o_valid,
  output logic [Y_W-1:0] o_y,
  output logic           o_in_window,
  output logic           o_retire
);

  logic           r_valid;
  logic [Y_W-1:0] r_y;
  logic [Y_W-1:0] w_y_next;

  assign w_y_next = r_y + SPEED;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_y     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_y     <= '0;
    end else if (i_adv && r_valid) begin
      if (w_y_next >= BOTTOM_Y) r_valid <= 1'b0;
      else                      r_y     <= w_y_next;
    end
  end

  assign o_valid     = r_valid;
  assign o_y         = r_y;
  assign o_in_window = r_valid && (r_y >= HIT_Y_LO) && (r_y <= HIT_Y_HI);
  assign o_retire    = r_valid && (w_y_next >= BOTTOM_Y);

endmodule

// File: rtl/note_lane.sv
// Per-lane note scroller: a frame tick sweeps NUM_SLOTS cycles; pulses and read port are 1-cycle registered.
// Never stalls: early spawns pulse overflow, hits/ticks during a sweep queue one deep. Score under NOTE_LANE_SCORE_EN.
module note_lane
  import note_pkg::*;
#(
  parameter int                 NUM_SLOTS  = 4,
  parameter logic [X_W-1:0]     LANE_X     = 10'd100,
  parameter logic [WIDTH_W-1:0] NOTE_WIDTH = 7'd40,
  parameter logic [Y_W-1:0]     SPEED      = 32'd2,
  parameter logic [Y_W-1:0]     BOTTOM_Y   = Y_W'(SCREEN_H),
  parameter logic [Y_W-1:0]     HIT_Y_LO   = 32'd400,
  parameter logic [Y_W-1:0]     HIT_Y_HI   = 32'd440
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_frame_tick,
  input  logic                         i_spawn,
  output logic                         o_spawn_ready,
  input  logic                         i_hit,
  output logic                         o_hit_ok,
  output logic                         o_hit_miss,
  output logic                         o_note_dropped,
  output logic                         o_overflow,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_rd_slot,
  output logic                         o_rd_valid,
  output logic [Y_W-1:0]               o_note_y,
  output logic [X_W-1:0]               o_note_x,
  output logic [WIDTH_W-1:0]           o_note_width,
  output logic [15:0]                  o_score
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_t               r_state, w_state_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic                 r_hit_pend, w_hit_pend_next;
  logic                 r_tick_pend, w_tick_pend_next;
  logic                 r_hit_ok, r_hit_miss, r_dropped, r_overflow;
  logic                 w_hit_ok, w_hit_miss, w_dropped, w_overflow;
  logic                 w_tick, w_resolve;
  logic [NUM_SLOTS-1:0] w_valid, w_in_win, w_retire, w_load, w_adv, w_clear;
  logic [Y_W-1:0]       w_y [NUM_SLOTS];
  logic                 w_any_free, w_any_win;
  logic [IDX_W-1:0]     w_free_idx, w_win_idx;
  logic                 r_rd_valid;
  logic [Y_W-1:0]       r_note_y;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(
      .SPEED   (SPEED),
      .BOTTOM_Y(BOTTOM_Y),
      .HIT_Y_LO(HIT_Y_LO),
      .HIT_Y_HI(HIT_Y_HI)
    ) u_slot (
      .i_clk      (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_load[g]),
      .i_adv      (w_adv[g]),
      .i_clear    (w_clear[g]),
      .o_valid    (w_valid[g]),
      .o_y        (w_y[g]),
      .o_in_window(w_in_win[g]),
      .o_retire   (w_retire[g])
    );
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    w_any_win  = 1'b0;
    w_win_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (w_in_win[i]) begin
        w_any_win = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
  end

  assign o_spawn_ready = (r_state == ST_IDLE) && w_any_free;
  assign w_tick        = i_frame_tick || r_tick_pend;

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_hit_pend_next  = r_hit_pend;
    w_tick_pend_next = r_tick_pend;
    w_hit_ok         = 1'b0;
    w_hit_miss       = 1'b0;
    w_dropped        = 1'b0;
    w_overflow       = 1'b0;
    w_resolve        = 1'b0;
    w_load           = '0;
    w_adv            = '0;
    w_clear          = '0;
    unique case (r_state)
      ST_IDLE: begin
        // A deferred hit always resolves here; a fresh hit is held if it cannot be served this cycle.
        w_resolve       = r_hit_pend || (i_hit && !w_tick);
        w_hit_pend_next = i_hit && (r_hit_pend || w_tick);
        if (w_resolve) begin
          if (w_any_win) begin
            w_clear[w_win_idx] = 1'b1;
            w_hit_ok           = 1'b1;
          end else begin
            w_hit_miss = 1'b1;
          end
        end
        if (w_tick) begin
          w_state_next     = ST_SWEEP;
          w_idx_next       = '0;
          w_tick_pend_next = 1'b0;
          w_overflow       = i_spawn;
        end else if (i_spawn) begin
          if (w_any_free) w_load[w_free_idx] = 1'b1;
          else            w_overflow         = 1'b1;
        end
      end
      ST_SWEEP: begin
        w_adv[r_idx] = 1'b1;
        w_dropped    = w_retire[r_idx];
        w_overflow   = i_spawn;
        if (i_frame_tick) w_tick_pend_next = 1'b1;
        if (i_hit)        w_hit_pend_next  = 1'b1;
        if (r_idx == IDX_W'(NUM_SLOTS - 1)) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + IDX_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_hit_pend  <= 1'b0;
      r_tick_pend <= 1'b0;
      r_hit_ok    <= 1'b0;
      r_hit_miss  <= 1'b0;
      r_dropped   <= 1'b0;
      r_overflow  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_note_y    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_hit_pend  <= w_hit_pend_next;
      r_tick_pend <= w_tick_pend_next;
      r_hit_ok    <= w_hit_ok;
      r_hit_miss  <= w_hit_miss;
      r_dropped   <= w_dropped;
      r_overflow  <= w_overflow;
      r_rd_valid  <= w_valid[i_rd_slot];
      r_note_y    <= w_valid[i_rd_slot] ? w_y[i_rd_slot] : '0;
    end
  end

`ifdef NOTE_LANE_SCORE_EN
  logic [15:0] r_score;
  always_ff @(posedge i_clock) begin
    if (i_reset)                             r_score <= '0;
    else if (w_hit_ok && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
  end
  assign o_score = r_score;
`else
  assign o_score = '0;
`endif

  assign o_hit_ok       = r_hit_ok;
  assign o_hit_miss     = r_hit_miss;
  assign o_note_dropped = r_dropped;
  assign o_overflow     = r_overflow;
  assign o_rd_valid     = r_rd_valid;
  assign o_note_y       = r_note_y;
  assign o_note_x       = LANE_X;
  assign o_note_width   = NOTE_WIDTH;

endmodule
